// File: rtl/countdown_timer.sv
// countdown_timer
//   MM:SS.mmm countdown for the board's seven-segment display. A preset of
//   minutes/seconds is loaded, then decremented once per millisecond while
//   running. Expiry is flagged on `done`; counters hold at zero afterwards.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   load       one-cycle pulse: capture set_min/set_sec (clamped to 59), go IDLE
//   set_min    preset minutes (0..59, larger values clamp to 59)
//   set_sec    preset seconds (0..59, larger values clamp to 59)
//   start      one-cycle pulse: begin (IDLE) or resume (PAUSE) counting
//   pause      one-cycle pulse: freeze counting (RUN only)
//   HEX0..HEX3 seg7 of sec%10, sec/10, min%10, min/10
//   milesimos  remaining milliseconds, 0..999
//   running    high while counting
//   done       high once the count has expired (or zero time was started)

module seg7 (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    // Active-low segments, bit order gfedcba. Non-decimal codes blank.
    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

module countdown_timer #(
    parameter int unsigned TICKS_PER_MS = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       start,
    input  logic       pause,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [9:0] milesimos,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICKS_PER_MS - 1);

    state_t      state, state_next;
    logic [15:0] cont, cont_next;
    logic [9:0]  ms_next;
    logic [5:0]  segundos, segundos_next;
    logic [5:0]  minutos, minutos_next;

    logic        tick;
    logic        time_zero;
    logic        last_ms;
    logic [5:0]  min_clamped;
    logic [5:0]  sec_clamped;

    assign min_clamped = (set_min > 6'd59) ? 6'd59 : set_min;
    assign sec_clamped = (set_sec > 6'd59) ? 6'd59 : set_sec;

    // The prescaler only advances in RUN, so a millisecond tick can only
    // happen there; PAUSE keeps the partial count for the resume.
    assign tick      = (state == RUN) && (cont == TICK_LAST);
    assign time_zero = (milesimos == 10'd0) && (segundos == 6'd0) && (minutos == 6'd0);
    // Tick that lands exactly on 00:00.000.
    assign last_ms   = tick && (milesimos == 10'd1) && (segundos == 6'd0) && (minutos == 6'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cont      <= '0;
            milesimos <= '0;
            segundos  <= '0;
            minutos   <= '0;
        end else begin
            state     <= state_next;
            cont      <= cont_next;
            milesimos <= ms_next;
            segundos  <= segundos_next;
            minutos   <= minutos_next;
        end
    end

    always_comb begin
        state_next    = state;
        cont_next     = cont;
        ms_next       = milesimos;
        segundos_next = segundos;
        minutos_next  = minutos;

        if (load) begin
            // Load overrides everything, including start/pause this cycle.
            minutos_next  = min_clamped;
            segundos_next = sec_clamped;
            ms_next       = '0;
            cont_next     = '0;
            state_next    = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = time_zero ? DONE : RUN;
                    end
                end

                RUN: begin
                    cont_next = tick ? '0 : cont + 16'd1;

                    if (tick) begin
                        if (milesimos != 10'd0) begin
                            ms_next = milesimos - 10'd1;
                        end else if (segundos != 6'd0) begin
                            ms_next       = 10'd999;
                            segundos_next = segundos - 6'd1;
                        end else if (minutos != 6'd0) begin
                            ms_next       = 10'd999;
                            segundos_next = 6'd59;
                            minutos_next  = minutos - 6'd1;
                        end
                    end

                    // Expiry beats a pause arriving on the same edge.
                    if (last_ms) begin
                        state_next = DONE;
                    end else if (pause) begin
                        state_next = PAUSE;
                    end
                end

                PAUSE: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end

                DONE: begin
                    state_next = DONE;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;

    assign sec_ones = 4'(segundos % 6'd10);
    assign sec_tens = 4'(segundos / 6'd10);
    assign min_ones = 4'(minutos % 6'd10);
    assign min_tens = 4'(minutos / 6'd10);

    seg7 u_seg_hex0 (.digit(sec_ones), .seg(HEX0));
    seg7 u_seg_hex1 (.digit(sec_tens), .seg(HEX1));
    seg7 u_seg_hex2 (.digit(min_ones), .seg(HEX2));
    seg7 u_seg_hex3 (.digit(min_tens), .seg(HEX3));

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer (TICKS_PER_MS = 4).
// The driver applies one set of inputs per cycle and pushes the expected
// post-edge outputs from a millisecond-count reference model; a monitor pops
// and compares shortly after each rising edge.

module tb_countdown_timer;

    localparam int T = 4;

    logic       clk;
    logic       rst;
    logic       load;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       start;
    logic       pause;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    logic [9:0] milesimos;
    logic       running;
    logic       done;

    countdown_timer #(.TICKS_PER_MS(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .start     (start),
        .pause     (pause),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .milesimos (milesimos),
        .running   (running),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rem_ms;
        bit run;
        bit fin;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: remaining time as a single millisecond count.
    int rem;
    int phase;
    bit m_run;
    bit m_pause;
    bit m_done;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic compare_outputs(input string tag, input int r, input bit run, input bit fin);
        int mins = r / 60000;
        int secs = (r / 1000) % 60;
        chk({tag, ".milesimos"}, int'(milesimos), r % 1000);
        chk({tag, ".HEX0"}, int'(HEX0), int'(seg_of(secs % 10)));
        chk({tag, ".HEX1"}, int'(HEX1), int'(seg_of(secs / 10)));
        chk({tag, ".HEX2"}, int'(HEX2), int'(seg_of(mins % 10)));
        chk({tag, ".HEX3"}, int'(HEX3), int'(seg_of(mins / 10)));
        chk({tag, ".running"}, int'(running), int'(run));
        chk({tag, ".done"}, int'(done), int'(fin));
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            compare_outputs("cyc", e.rem_ms, e.run, e.fin);
        end
    end

    function automatic void model_reset();
        rem     = 0;
        phase   = 0;
        m_run   = 0;
        m_pause = 0;
        m_done  = 0;
    endfunction

    function automatic void model_edge(input bit l, input bit s, input bit p,
                                       input int mn, input int sc);
        if (l) begin
            rem     = ((mn > 59) ? 59 : mn) * 60000 + ((sc > 59) ? 59 : sc) * 1000;
            phase   = 0;
            m_run   = 0;
            m_pause = 0;
            m_done  = 0;
        end else if (m_run) begin
            phase++;
            if (phase == T) begin
                phase = 0;
                if (rem > 0) rem--;
                if (rem == 0) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
            if (m_run && p) begin
                m_run   = 0;
                m_pause = 1;
            end
        end else if (m_pause) begin
            if (s) begin
                m_pause = 0;
                m_run   = 1;
            end
        end else if (!m_done) begin
            if (s) begin
                if (rem > 0) m_run = 1;
                else         m_done = 1;
            end
        end
    endfunction

    task automatic step(input bit l, input bit s, input bit p, input int mn, input int sc);
        exp_t e;
        @(negedge clk);
        load    = l;
        start   = s;
        pause   = p;
        set_min = 6'(mn);
        set_sec = 6'(sc);
        model_edge(l, s, p, mn, sc);
        e.rem_ms = rem;
        e.run    = m_run;
        e.fin    = m_done;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        compare_outputs("async_rst", 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst     = 1'b1;
        load    = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        set_min = '0;
        set_sec = '0;
        model_reset();
        #1;
        compare_outputs("reset", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Load with clamping.
        step(1, 0, 0, 63, 5);
        step(1, 0, 0, 12, 62);
        idle(2);

        // Minute borrow: 01:00 -> 00:59.999 on the first tick.
        step(1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        idle(6);

        // Reset while running.
        async_reset();
        idle(2);

        // Full expiry from 00:02, then hold at zero.
        step(1, 0, 0, 0, 2);
        step(0, 1, 0, 0, 0);
        guard = 0;
        while (!m_done && guard < 12000) begin
            step(0, 0, 0, 0, 0);
            guard++;
        end
        chk("expiry_within_budget", int'(guard < 12000), 1);
        idle(100);

        // Pause/resume keeps the partial millisecond.
        step(1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        idle(9);
        step(0, 0, 1, 0, 0);
        idle(5);
        step(0, 1, 0, 0, 0);
        idle(6);

        // Zero load, start -> DONE; start ignored; load leaves DONE.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(3);
        step(1, 0, 0, 0, 3);
        idle(2);

        // Priorities: load+start, then start+pause in RUN.
        step(1, 1, 0, 0, 4);
        idle(2);
        step(0, 1, 0, 0, 0);
        idle(3);
        step(0, 1, 1, 0, 0);
        idle(3);
        step(0, 1, 1, 0, 0);
        idle(5);

        // Randomized pulses and presets.
        for (int i = 0; i < 6000; i++) begin
            int r;
            bit l, s, p;
            int mn, sc;
            r  = int'($urandom_range(0, 999));
            l  = (r < 4);
            s  = (r >= 4 && r < 40) || (r >= 990);
            p  = (r >= 40 && r < 60) || (r >= 990);
            if ($urandom_range(0, 3) == 0) begin
                mn = int'($urandom_range(0, 63));
                sc = int'($urandom_range(0, 63));
            end else begin
                mn = 0;
                sc = int'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 1999) == 0) async_reset();
            step(l, s, p, mn, sc);
        end

        // Drain the scoreboard.
        @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Countdown timer for the board's MM:SS seven-segment display, the down-counting counterpart of the stopwatch. A preset of minutes and seconds is loaded, then decremented at millisecond resolution while running. The block drives HEX0..HEX3 through the existing `seg7` decoder and flags expiry for the top level.

## Interface
- `TICKS_PER_MS`, 50000: clk cycles per millisecond (50 MHz board clock); minimum 2.
- `clk  in  1`: system clock, all state on rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `load  in  1`: one-cycle pulse; capture `set_min`/`set_sec` as the new remaining time.
- `set_min  in  6`: preset minutes, 0..59; values above 59 are clamped to 59.
- `set_sec  in  6`: preset seconds, 0..59; values above 59 are clamped to 59.
- `start  in  1`: one-cycle pulse; begin or resume counting.
- `pause  in  1`: one-cycle pulse; freeze counting.
- `HEX0  out  7`: `seg7` of seconds mod 10.
- `HEX1  out  7`: `seg7` of seconds / 10.
- `HEX2  out  7`: `seg7` of minutes mod 10.
- `HEX3  out  7`: `seg7` of minutes / 10.
- `milesimos  out  10`: remaining milliseconds, 0..999.
- `running  out  1`: high in RUN.
- `done  out  1`: high in DONE.

## Operation
- State registers:
  - `cont`: 16-bit prescaler.
  - `milesimos`: 10 bits.
  - `segundos`: 6 bits.
  - `minutos`: 6 bits.
  - FSM: IDLE, RUN, PAUSE, DONE.
- Reset: state IDLE, all counters 0, `running`=0, `done`=0, HEX0..3 = `seg7(0)`.
- `load` (any state, highest priority):
  - `minutos`/`segundos` ← clamped presets; `milesimos` ← 0; `cont` ← 0.
  - State ← IDLE. `start`/`pause` in the same cycle are ignored.
- IDLE + `start`:
  - If the loaded time is nonzero → RUN.
  - If the loaded time is 00:00.000 → DONE.
- RUN + `pause` → PAUSE. `pause` wins over a simultaneous `start`.
- PAUSE + `start` → RUN.
- `start` in RUN or DONE is ignored. `pause` outside RUN is ignored.
- DONE is left only by `load` or `rst`.
- Prescaler: only in RUN, `cont` increments each cycle.
  - At `cont == TICKS_PER_MS-1`: `cont` ← 0 and one ms tick is produced. Period is exactly `TICKS_PER_MS` cycles.
  - In PAUSE, `cont` holds its value, so resuming does not lose a partial millisecond.
- Decrement on each tick, borrowing down the chain:
  - If `milesimos` > 0: `milesimos`−1.
  - Else if `segundos` > 0: `milesimos`←999, `segundos`−1.
  - Else if `minutos` > 0: `milesimos`←999, `segundos`←59, `minutos`−1.
- Expiry: on the tick whose result is 00:00.000, the FSM goes to DONE in the same edge. Counters hold at zero; no wrap to 59:59.
- Arithmetic: all counters unsigned. The time never goes below zero.
- Displays: HEX digits are purely combinational from `segundos`/`minutos` via `seg7`.

## Timing
- `load` at edge N: new values visible after edge N; HEX updates combinationally from those registers.
- `start` at edge N: `running`=1 after edge N. The first tick occurs `TICKS_PER_MS` cycles later.
- Reaching zero: the decrementing edge also sets `done`=1 and `running`=0.
- `pause` at edge N: `running`=0 after N; no further decrement from edge N+1 onward.
- `rst` mid-count: all outputs reach their reset values immediately and asynchronously.

## Test plan
All scenarios use `TICKS_PER_MS`=4 unless stated.
- Reset: assert `rst` mid-RUN → `milesimos`=0, `running`=0, `done`=0, HEX0..3 = `seg7(0)` without waiting for a clk edge.
- Load with clamp: `load` with `set_min`=63, `set_sec`=5 → `minutos`=59, `segundos`=5, `milesimos`=0, state IDLE.
- Borrow chain: load 01:00, `start`, wait 4 cycles → 00:59, `milesimos`=999. After 59,999 further ticks → `done`=1, `running`=0, display 00:00. Counters then stay at 0 for another 100 cycles.
- Pause/resume: load 00:01, `start`, `pause` after 10 cycles → value frozen at `milesimos`=998 with `cont`=2. `start` → next tick after 2 more cycles.
- Zero load: load 00:00, `start` → `done`=1 after one edge. Further `start` keeps DONE; `load` 00:03 → IDLE, `done`=0.
- Priority: `load` and `start` on the same cycle → IDLE with the new value. `start` and `pause` together in RUN → PAUSE.
